// File: rtl/vga_pkg.sv
// Shared raster timing definitions for the VGA timing generator and the
// sprite modules that consume its scan coordinates.
package vga_pkg;

    // Scan coordinate as seen by every sprite module (DrawX / DrawY).
    typedef logic [9:0] coord_t;

    // Default 640x480@60 Hz timing, in pixels (horizontal) and lines (vertical).
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    // Derived default totals and sync windows; the sync windows are half-open
    // [START, END), so sync is asserted for counts START..END-1.
    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

endpackage

// File: rtl/vga_pixel_div.sv
// Pixel-rate enable: divides Clk by CLK_DIV and marks the last Clk of each
// pixel slot, so the first enable after reset release lands CLK_DIV-1 edges
// later. With CLK_DIV = 1 the enable is permanently high.
module vga_pixel_div #(
    parameter int CLK_DIV = 2
) (
    input  logic Clk,
    input  logic reset,
    output logic pixel_ce
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    // Free-running modulo-CLK_DIV counter, restarted by reset.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create ordering-dependent logic.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign pixel_ce = (div_cnt == LAST);

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: pixel/line counters, sync decode and per-frame
// markers that drive the sprite modules and the colour mapper.
module vga_timing
    import vga_pkg::coord_t;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_pkg::H_FRONT,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BACK    = vga_pkg::H_BACK,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_pkg::V_FRONT,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BACK    = vga_pkg::V_BACK
) (
    input  logic        Clk,
    input  logic        reset,
    output logic        pixel_ce,
    output coord_t      DrawX,
    output coord_t      DrawY,
    output logic        hs,
    output logic        vs,
    output logic        pixel_valid,
    output logic        frame_clk,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    coord_t h_cnt;
    coord_t v_cnt;
    logic   h_last;
    logic   v_last;
    logic   frame_wrap;

    vga_pixel_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_div (
        .Clk      (Clk),
        .reset    (reset),
        .pixel_ce (pixel_ce)
    );

    assign h_last     = (h_cnt == coord_t'(H_TOTAL - 1));
    assign v_last     = (v_cnt == coord_t'(V_TOTAL - 1));
    // Edge that takes the raster from the last pixel of the frame back to (0,0).
    assign frame_wrap = pixel_ce && h_last && v_last;

    // Horizontal and vertical scan counters; the line counter steps on the
    // same pixel edge that wraps the pixel counter, so both wrap together.
    // NOTE: only the counters carry an async reset; the decoded outputs are
    // combinational from them and therefore follow reset without a clock.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pixel_ce) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? coord_t'(0) : v_cnt + coord_t'(1);
            end else begin
                h_cnt <= h_cnt + coord_t'(1);
            end
        end
    end

    // One-Clk start-of-frame pulse and completed-frame counter (wraps mod 2^16).
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    // Coordinates come straight from the counters and are not clamped in
    // blanking; sync and valid are decoded from the same registers so they
    // stay aligned with DrawX/DrawY.
    assign DrawX       = h_cnt;
    assign DrawY       = v_cnt;
    assign hs          = !((h_cnt >= coord_t'(H_SYNC_START)) && (h_cnt < coord_t'(H_SYNC_END)));
    assign vs          = !((v_cnt >= coord_t'(V_SYNC_START)) && (v_cnt < coord_t'(V_SYNC_END)));
    assign pixel_valid = (h_cnt < coord_t'(H_VISIBLE)) && (v_cnt < coord_t'(V_VISIBLE));
    // Sprites update on the rising edge of this, i.e. when vsync ends.
    assign frame_clk   = vs;

endmodule

// File: tb/tb_vga_timing.sv
// Randomised-reset scoreboard bench for vga_timing. Three instances share Clk
// and reset: default horizontal timing with a short frame (CLK_DIV=2), a tiny
// raster with CLK_DIV=1, and a tiny raster with CLK_DIV=3. The reference model
// derives every output from the number of Clk edges since reset release.
module tb_vga_timing;

    import vga_pkg::coord_t;

    localparam int NDUT = 3;

    typedef struct packed {
        int div;
        int hv, hf, hsw, hb;
        int vv, vf, vsw, vb;
    } timing_t;

    localparam timing_t CFG0 = '{2, vga_pkg::H_VISIBLE, vga_pkg::H_FRONT, vga_pkg::H_SYNC,
                                 vga_pkg::H_BACK, 4, 2, 2, 2};
    localparam timing_t CFG1 = '{1, 8, 2, 2, 2, 4, 1, 1, 1};
    localparam timing_t CFG2 = '{3, 10, 3, 4, 2, 5, 2, 3, 1};

    typedef struct packed {
        logic        ce;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        fclk;
        logic        pv;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    typedef struct {
        int    id;
        obs_t  e;
        string tag;
    } item_t;

    logic        clk;
    logic        rst_n;
    logic        pce   [NDUT];
    coord_t      dx    [NDUT];
    coord_t      dy    [NDUT];
    logic        hsync [NDUT];
    logic        vsync [NDUT];
    logic        pval  [NDUT];
    logic        fclk  [NDUT];
    logic        fstart[NDUT];
    logic [15:0] fcnt  [NDUT];

    int unsigned k;            // Clk edges since reset release
    int unsigned checks;
    int unsigned errors;
    int unsigned fclk_edges;
    logic        fclk_prev;
    item_t       sb_q[$];
    event        sample_ev;

    vga_timing #(
        .CLK_DIV(CFG0.div), .H_VISIBLE(CFG0.hv), .H_FRONT(CFG0.hf), .H_SYNC(CFG0.hsw),
        .H_BACK(CFG0.hb), .V_VISIBLE(CFG0.vv), .V_FRONT(CFG0.vf), .V_SYNC(CFG0.vsw),
        .V_BACK(CFG0.vb)
    ) dut0 (
        .Clk(clk), .reset(rst_n), .pixel_ce(pce[0]), .DrawX(dx[0]), .DrawY(dy[0]),
        .hs(hsync[0]), .vs(vsync[0]), .pixel_valid(pval[0]), .frame_clk(fclk[0]),
        .frame_start(fstart[0]), .frame_count(fcnt[0])
    );

    vga_timing #(
        .CLK_DIV(CFG1.div), .H_VISIBLE(CFG1.hv), .H_FRONT(CFG1.hf), .H_SYNC(CFG1.hsw),
        .H_BACK(CFG1.hb), .V_VISIBLE(CFG1.vv), .V_FRONT(CFG1.vf), .V_SYNC(CFG1.vsw),
        .V_BACK(CFG1.vb)
    ) dut1 (
        .Clk(clk), .reset(rst_n), .pixel_ce(pce[1]), .DrawX(dx[1]), .DrawY(dy[1]),
        .hs(hsync[1]), .vs(vsync[1]), .pixel_valid(pval[1]), .frame_clk(fclk[1]),
        .frame_start(fstart[1]), .frame_count(fcnt[1])
    );

    vga_timing #(
        .CLK_DIV(CFG2.div), .H_VISIBLE(CFG2.hv), .H_FRONT(CFG2.hf), .H_SYNC(CFG2.hsw),
        .H_BACK(CFG2.hb), .V_VISIBLE(CFG2.vv), .V_FRONT(CFG2.vf), .V_SYNC(CFG2.vsw),
        .V_BACK(CFG2.vb)
    ) dut2 (
        .Clk(clk), .reset(rst_n), .pixel_ce(pce[2]), .DrawX(dx[2]), .DrawY(dy[2]),
        .hs(hsync[2]), .vs(vsync[2]), .pixel_valid(pval[2]), .frame_clk(fclk[2]),
        .frame_start(fstart[2]), .frame_count(fcnt[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic timing_t cfg(int id);
        case (id)
            0:       return CFG0;
            1:       return CFG1;
            default: return CFG2;
        endcase
    endfunction

    // Reference model: after kk edges, kk/div pixels have elapsed; position,
    // sync windows and frame number follow from plain division.
    function automatic obs_t expect_obs(int id, int unsigned kk);
        timing_t     c;
        obs_t        e;
        int unsigned ht, vt, ft, p, pos, x, y;
        c   = cfg(id);
        ht  = c.hv + c.hf + c.hsw + c.hb;
        vt  = c.vv + c.vf + c.vsw + c.vb;
        ft  = ht * vt;
        p   = kk / c.div;
        pos = p % ft;
        x   = pos % ht;
        y   = pos / ht;
        e.ce   = ((kk % c.div) == (c.div - 1));
        e.x    = 10'(x);
        e.y    = 10'(y);
        e.hs   = !((x >= c.hv + c.hf) && (x < c.hv + c.hf + c.hsw));
        e.vs   = !((y >= c.vv + c.vf) && (y < c.vv + c.vf + c.vsw));
        e.fclk = e.vs;
        e.pv   = (x < c.hv) && (y < c.vv);
        e.fs   = (kk != 0) && ((kk % c.div) == 0) && (pos == 0);
        e.fc   = 16'(p / ft);
        return e;
    endfunction

    function automatic obs_t observe(int id);
        obs_t g;
        g.ce   = pce[id];
        g.x    = dx[id];
        g.y    = dy[id];
        g.hs   = hsync[id];
        g.vs   = vsync[id];
        g.fclk = fclk[id];
        g.pv   = pval[id];
        g.fs   = fstart[id];
        g.fc   = fcnt[id];
        return g;
    endfunction

    task automatic check(string name, int id, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %0d, expected %0d", name, id, $time, got, exp);
        end
    endtask

    // Edge counter of the model: reset clears it asynchronously.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    // Downstream-style rising-edge detector on dut0's frame_clk.
    always @(posedge clk) begin
        fclk_prev <= fclk[0];
        if (!fclk_prev && fclk[0]) fclk_edges <= fclk_edges + 1;
    end

    // Producer: one expected observation per instance on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int id = 0; id < NDUT; id++) sb_q.push_back('{id, expect_obs(id, k), "cyc"});
            ->sample_ev;
        end
    end

    // Monitor: drains the scoreboard whenever an observation point is signalled.
    initial begin
        item_t it;
        obs_t  g;
        forever begin
            @(sample_ev);
            while (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                g  = observe(it.id);
                check({it.tag, ".pixel_ce"},    it.id, 32'(g.ce),   32'(it.e.ce));
                check({it.tag, ".DrawX"},       it.id, 32'(g.x),    32'(it.e.x));
                check({it.tag, ".DrawY"},       it.id, 32'(g.y),    32'(it.e.y));
                check({it.tag, ".hs"},          it.id, 32'(g.hs),   32'(it.e.hs));
                check({it.tag, ".vs"},          it.id, 32'(g.vs),   32'(it.e.vs));
                check({it.tag, ".frame_clk"},   it.id, 32'(g.fclk), 32'(it.e.fclk));
                check({it.tag, ".pixel_valid"}, it.id, 32'(g.pv),   32'(it.e.pv));
                check({it.tag, ".frame_start"}, it.id, 32'(g.fs),   32'(it.e.fs));
                check({it.tag, ".frame_count"}, it.id, 32'(g.fc),   32'(it.e.fc));
            end
        end
    end

    // Asserts reset mid-cycle and checks that outputs clear before any Clk edge.
    task automatic async_reset(string tag);
        rst_n = 1'b0;
        #1;
        for (int id = 0; id < NDUT; id++) sb_q.push_back('{id, expect_obs(id, 0), tag});
        ->sample_ev;
    endtask

    task automatic release_reset(int unsigned hold);
        repeat (hold) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int unsigned edges_start;
        checks     = 0;
        errors     = 0;
        fclk_edges = 0;
        fclk_prev  = 1'b1;
        rst_n      = 1'b0;

        // Reset, release, run dut0 to DrawX=700, DrawY=7 (inside both syncs).
        release_reset(3);
        repeat (12600) @(posedge clk);
        #2;
        check("pre_reset.hs_low",  0, 32'(hsync[0]), 32'd0);
        check("pre_reset.vs_low",  0, 32'(vsync[0]), 32'd0);
        check("pre_reset.DrawX",   0, 32'(dx[0]),    32'd700);
        async_reset("mid_sync_reset");

        // Three full frames of dut0: one frame_clk rising edge per frame.
        release_reset(2);
        @(posedge clk);
        edges_start = fclk_edges;
        repeat (48100) @(posedge clk);
        #2;
        check("frame_clk_edges", 0, 32'(fclk_edges - edges_start), 32'd3);
        check("frame_count_3",   0, 32'(fcnt[0]),                  32'd3);

        // Random-length runs broken by resets at random points within the cycle.
        for (int n = 0; n < 6; n++) begin
            repeat ($urandom_range(50, 2000)) @(posedge clk);
            #($urandom_range(1, 3));
            async_reset("rand_reset");
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #($urandom_range(1, 3));
            rst_n = 1'b1;
        end
        repeat (700) @(posedge clk);

        @(negedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Raster timing generator that produces the DrawX/DrawY scan coordinates, sync pulses and the per-frame frame_clk used by the sprite modules (arrow, receptor, score overlay).
- Sprite modules take DrawX/DrawY/frame_clk from this block and return display bits. The colour mapper consumes those bits together with pixel_valid.
- Defaults give 640x480@60 Hz from a 50 MHz Clk, using a divide-by-2 pixel enable.

Parameters:
- CLK_DIV, 2, Clk cycles per pixel (1..4)
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- Clk, input, 1, system clock (50 MHz)
- reset, input, 1, asynchronous, active-low reset
- pixel_ce, output, 1, one-Clk pulse marking each pixel slot
- DrawX, output, 10, current horizontal count, 0..H_TOTAL-1
- DrawY, output, 10, current vertical count, 0..V_TOTAL-1
- hs, output, 1, horizontal sync, active low
- vs, output, 1, vertical sync, active low
- pixel_valid, output, 1, high when DrawX < H_VISIBLE and DrawY < V_VISIBLE
- frame_clk, output, 1, equals vs; its rising edge (end of vsync) is the sprite update point
- frame_start, output, 1, one-Clk pulse when the counters wrap to (0,0)
- frame_count, output, 16, number of completed frames, wraps at 65535 -> 0

Behaviour:
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800 by default). V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525 by default). Both must fit in 10 bits.
- div_cnt counts 0..CLK_DIV-1 on every Clk. pixel_ce = (div_cnt == CLK_DIV-1). With CLK_DIV=1, pixel_ce is constantly high.
- h_cnt advances only on a Clk edge where pixel_ce=1. At H_TOTAL-1 it wraps to 0.
- v_cnt increments on the same edge where h_cnt wraps. At V_TOTAL-1 it wraps to 0.
- DrawX = h_cnt and DrawY = v_cnt, both driven directly from registers with zero latency. They are not clamped during blanking.
- hs = 0 iff H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751 by default).
- vs = 0 iff V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491 by default). vs is a function of v_cnt only.
- Decoded outputs are combinational from the counter registers. hs, vs and pixel_valid are therefore aligned with DrawX/DrawY in the same cycle.
- frame_start is a registered pulse, high for exactly one Clk, on the cycle after the edge that moves (h,v) from (H_TOTAL-1, V_TOTAL-1) to (0,0). It coincides with DrawX=0, DrawY=0.
- frame_count increments on that same edge and wraps modulo 2^16.
- frame_clk rises once per frame, when v_cnt leaves the last sync line (492 by default). Consumers do their own rising-edge detection in the Clk domain.
- Reset asserted (reset=0), at any time including mid-line or mid-sync:
  - div_cnt=0, h_cnt=0, v_cnt=0, frame_count=0, frame_start=0.
  - This gives DrawX=0, DrawY=0, hs=1, vs=1, frame_clk=1, pixel_valid=1, pixel_ce=(CLK_DIV==1).
  - The first pixel_ce after release occurs CLK_DIV-1 Clk edges later.
- Simultaneous h-wrap and v-wrap: both counters go to 0 on the same edge. v_cnt never equals V_TOTAL.

Decomposition:
- Package vga_pkg holds:
  - the default timing constants (H_*, V_*);
  - derived H_TOTAL, V_TOTAL, H_SYNC_START/END, V_SYNC_START/END;
  - a coord_t typedef (logic [9:0]).
- Sprite modules import coord_t from vga_pkg.
- One natural sub-module, vga_pixel_div: the CLK_DIV counter producing pixel_ce.
- The h/v counters and decode stay in vga_timing.

Test Plan:
- Reset then release, CLK_DIV=2: DrawX/DrawY=0 and hs=vs=1 during reset. First pixel_ce appears 1 Clk after release. DrawX reaches 1 on the 2nd Clk after release.
- One full line: hs low for exactly 96 pixel_ce periods (192 Clk), starting at DrawX=656. pixel_valid falls at DrawX=640. DrawX wraps 799->0 and DrawY increments 0->1 on the same edge.
- One full frame: vs low only for DrawY 490..491, i.e. 1600 pixel_ce periods. frame_start pulses exactly once, for 1 Clk, at (0,0). Frame length is 420000 pixel periods (840000 Clk). frame_count goes 0->1.
- frame_clk edge: exactly one rising edge per frame, at the transition DrawY 491->492. A downstream edge detector counts 3 edges over 3 frames.
- Reset mid-operation: assert reset at DrawX=700, DrawY=491 (hs=0, vs=0). Outputs immediately (asynchronously, before the next Clk) go to DrawX=0, DrawY=0, hs=1, vs=1, frame_count=0.
- CLK_DIV=1 with small timing (H 8/2/2/2, V 4/1/1/1): pixel_ce is constant 1, a line is 14 Clk and a frame is 98 Clk. frame_count wraps 65535->0 when forced near its limit.
